// File: rtl/splt_me_pkg.sv
// splt_me_pkg
//   Shared definitions for the ICB address splitter:
//   - clog2 helper used for FIFO pointer and count widths
//   - default per-port base address / compare mask tables for a
//     4-port, 32-bit address configuration (port k at bits [(k+1)*32-1:k*32])
package splt_me_pkg;

    localparam int unsigned DEF_SPLT_NUM = 4;
    localparam int unsigned DEF_AW       = 32;

    localparam logic [DEF_SPLT_NUM*DEF_AW-1:0] DEF_BASE_ADDR = {
        32'h4000_0000,
        32'h3000_0000,
        32'h2000_0000,
        32'h1000_0000
    };

    localparam logic [DEF_SPLT_NUM*DEF_AW-1:0] DEF_ADDR_MASK = {
        32'hF000_0000,
        32'hF000_0000,
        32'hF000_0000,
        32'hF000_0000
    };

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/splt_me_fifo.sv
// fifo_simple
//   Small synchronous FIFO holding outstanding target ids.
//   Ports:
//     clk_i       clock
//     rst_ni      synchronous active-low reset (empties the FIFO)
//     push_vld_i  push request
//     push_rdy_o  push accepted (not full; see CUT_READY)
//     push_dat_i  push data
//     pop_vld_o   head entry valid (FIFO not empty)
//     pop_rdy_i   pop request
//     pop_dat_o   head entry data
//   CUT_READY=1 makes push_rdy_o depend only on registered state, so a
//   simultaneous pop never frees a slot for a push in the same cycle.
module fifo_simple
    import splt_me_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned DP        = 2,
    parameter bit          CUT_READY = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_vld_i,
    output logic          push_rdy_o,
    input  logic [DW-1:0] push_dat_i,
    output logic          pop_vld_o,
    input  logic          pop_rdy_i,
    output logic [DW-1:0] pop_dat_o
);

    localparam int unsigned PW = (DP > 1) ? clog2(DP) : 1;
    localparam int unsigned CW = clog2(DP + 1);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic [DW-1:0] mem_q [DP];

    logic full, empty;
    logic push_en, pop_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full       = (cnt_q == CW'(DP));
        empty      = (cnt_q == '0);
        push_rdy_o = CUT_READY ? ~full : (~full | pop_rdy_i);
        push_en    = push_vld_i & push_rdy_o;
        pop_en     = pop_rdy_i & ~empty;
        pop_vld_o  = ~empty;
        pop_dat_o  = mem_q[rptr_q];
    end

    always_comb begin
        wptr_d = push_en ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop_en  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (push_en && !pop_en) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_en && !push_en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/splt_me.sv
// splt_me
//   ICB 1-to-N address splitter. One upstream command/response bus is
//   decoded by address onto SPLT_NUM downstream buses; unmapped addresses
//   go to an internal error target that answers with err=1.
//   Responses return strictly in command order, tracked by a FIFO of
//   one-hot target ids (bit SPLT_NUM = error target).
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     i_icb_cmd_*              upstream command (vld/rdy/read/addr/wdata/wmask/usr)
//     i_icb_rsp_*              upstream response (vld/rdy/err/rdata/usr)
//     o_bus_icb_cmd_*          downstream commands, packed per port
//     o_bus_icb_rsp_*          downstream responses, packed per port
module splt_me
    import splt_me_pkg::*;
#(
    parameter int unsigned              AW        = 32,
    parameter int unsigned              DW        = 32,
    parameter int unsigned              USR_W     = 1,
    parameter int unsigned              SPLT_NUM  = 4,
    parameter int unsigned              FIFO_DP   = 2,
    parameter logic [SPLT_NUM*AW-1:0]   BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [SPLT_NUM*AW-1:0]   ADDR_MASK = DEF_ADDR_MASK
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        i_icb_cmd_vld,
    output logic                        i_icb_cmd_rdy,
    input  logic                        i_icb_cmd_read,
    input  logic [AW-1:0]               i_icb_cmd_addr,
    input  logic [DW-1:0]               i_icb_cmd_wdata,
    input  logic [DW/8-1:0]             i_icb_cmd_wmask,
    input  logic [USR_W-1:0]            i_icb_cmd_usr,

    output logic                        i_icb_rsp_vld,
    input  logic                        i_icb_rsp_rdy,
    output logic                        i_icb_rsp_err,
    output logic [DW-1:0]               i_icb_rsp_rdata,
    output logic [USR_W-1:0]            i_icb_rsp_usr,

    output logic [SPLT_NUM-1:0]         o_bus_icb_cmd_vld,
    input  logic [SPLT_NUM-1:0]         o_bus_icb_cmd_rdy,
    output logic [SPLT_NUM-1:0]         o_bus_icb_cmd_read,
    output logic [SPLT_NUM*AW-1:0]      o_bus_icb_cmd_addr,
    output logic [SPLT_NUM*DW-1:0]      o_bus_icb_cmd_wdata,
    output logic [SPLT_NUM*DW/8-1:0]    o_bus_icb_cmd_wmask,
    output logic [SPLT_NUM*USR_W-1:0]   o_bus_icb_cmd_usr,

    input  logic [SPLT_NUM-1:0]         o_bus_icb_rsp_vld,
    output logic [SPLT_NUM-1:0]         o_bus_icb_rsp_rdy,
    input  logic [SPLT_NUM-1:0]         o_bus_icb_rsp_err,
    input  logic [SPLT_NUM*DW-1:0]      o_bus_icb_rsp_rdata,
    input  logic [SPLT_NUM*USR_W-1:0]   o_bus_icb_rsp_usr
);

    localparam int unsigned TW = SPLT_NUM + 1;

    logic [TW-1:0] tgt_oh;
    logic          tgt_rdy;
    logic          fifo_unfull;
    logic          fifo_push;
    logic          fifo_unempty;
    logic [TW-1:0] fifo_head;
    logic [TW-1:0] head_oh;
    logic          fifo_pop;

    // Address decode. Scanning from the highest port down and overwriting
    // leaves the lowest-index hit; no hit leaves the error target selected.
    always_comb begin
        tgt_oh           = '0;
        tgt_oh[SPLT_NUM] = 1'b1;
        for (int unsigned k = SPLT_NUM; k > 0; k--) begin
            if ((i_icb_cmd_addr & ADDR_MASK[(k-1)*AW +: AW]) ==
                (BASE_ADDR[(k-1)*AW +: AW] & ADDR_MASK[(k-1)*AW +: AW])) begin
                tgt_oh        = '0;
                tgt_oh[k-1]   = 1'b1;
            end
        end
    end

    // Command path: payload broadcast, valid steered to the decoded port.
    always_comb begin
        tgt_rdy = tgt_oh[SPLT_NUM] | (|(tgt_oh[SPLT_NUM-1:0] & o_bus_icb_cmd_rdy));
        i_icb_cmd_rdy       = fifo_unfull & tgt_rdy;
        fifo_push           = i_icb_cmd_vld & i_icb_cmd_rdy;
        o_bus_icb_cmd_vld   = tgt_oh[SPLT_NUM-1:0] & {SPLT_NUM{i_icb_cmd_vld & fifo_unfull}};
        o_bus_icb_cmd_read  = {SPLT_NUM{i_icb_cmd_read}};
        o_bus_icb_cmd_addr  = {SPLT_NUM{i_icb_cmd_addr}};
        o_bus_icb_cmd_wdata = {SPLT_NUM{i_icb_cmd_wdata}};
        o_bus_icb_cmd_wmask = {SPLT_NUM{i_icb_cmd_wmask}};
        o_bus_icb_cmd_usr   = {SPLT_NUM{i_icb_cmd_usr}};
    end

    // The FIFO head is registered, so a command pushed this cycle cannot
    // be answered until the next cycle.
    fifo_simple #(
        .DW        (TW),
        .DP        (FIFO_DP),
        .CUT_READY (1'b1)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .push_vld_i (fifo_push),
        .push_rdy_o (fifo_unfull),
        .push_dat_i (tgt_oh),
        .pop_vld_o  (fifo_unempty),
        .pop_rdy_i  (fifo_pop),
        .pop_dat_o  (fifo_head)
    );

    // Response path: only the head port is visible upstream; every other
    // port sees rdy=0 and simply holds its response.
    always_comb begin
        head_oh           = fifo_head & {TW{fifo_unempty}};
        o_bus_icb_rsp_rdy = head_oh[SPLT_NUM-1:0] & {SPLT_NUM{i_icb_rsp_rdy}};
        i_icb_rsp_vld     = head_oh[SPLT_NUM];
        i_icb_rsp_err     = head_oh[SPLT_NUM];
        i_icb_rsp_rdata   = '0;
        i_icb_rsp_usr     = '0;
        for (int unsigned k = 0; k < SPLT_NUM; k++) begin
            if (head_oh[k]) begin
                i_icb_rsp_vld   = o_bus_icb_rsp_vld[k];
                i_icb_rsp_err   = o_bus_icb_rsp_err[k];
                i_icb_rsp_rdata = o_bus_icb_rsp_rdata[k*DW +: DW];
                i_icb_rsp_usr   = o_bus_icb_rsp_usr[k*USR_W +: USR_W];
            end
        end
        fifo_pop = i_icb_rsp_vld & i_icb_rsp_rdy;
    end

endmodule

// File: tb/tb_splt_me.sv
module tb_splt_me;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DP = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            cmd_vld, cmd_rdy, cmd_read;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [3:0]      cmd_wmask;
    logic [0:0]      cmd_usr;
    logic            rsp_vld, rsp_rdy, rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic [0:0]      rsp_usr;

    logic [N-1:0]    b_cmd_vld, b_cmd_rdy, b_cmd_read;
    logic [N*AW-1:0] b_cmd_addr;
    logic [N*DW-1:0] b_cmd_wdata;
    logic [N*4-1:0]  b_cmd_wmask;
    logic [N-1:0]    b_cmd_usr;
    logic [N-1:0]    b_rsp_vld, b_rsp_rdy, b_rsp_err, b_rsp_usr;
    logic [DW-1:0]   p_rdata [N];
    logic [N*DW-1:0] b_rsp_rdata;

    always_comb begin
        b_rsp_rdata = '0;
        for (int k = 0; k < N; k++) b_rsp_rdata[k*DW +: DW] = p_rdata[k];
    end

    splt_me #(
        .AW        (AW),
        .DW        (DW),
        .USR_W     (1),
        .SPLT_NUM  (N),
        .FIFO_DP   (DP),
        .BASE_ADDR ({32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
        .ADDR_MASK ({4{32'hF000_0000}})
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_icb_cmd_vld       (cmd_vld),
        .i_icb_cmd_rdy       (cmd_rdy),
        .i_icb_cmd_read      (cmd_read),
        .i_icb_cmd_addr      (cmd_addr),
        .i_icb_cmd_wdata     (cmd_wdata),
        .i_icb_cmd_wmask     (cmd_wmask),
        .i_icb_cmd_usr       (cmd_usr),
        .i_icb_rsp_vld       (rsp_vld),
        .i_icb_rsp_rdy       (rsp_rdy),
        .i_icb_rsp_err       (rsp_err),
        .i_icb_rsp_rdata     (rsp_rdata),
        .i_icb_rsp_usr       (rsp_usr),
        .o_bus_icb_cmd_vld   (b_cmd_vld),
        .o_bus_icb_cmd_rdy   (b_cmd_rdy),
        .o_bus_icb_cmd_read  (b_cmd_read),
        .o_bus_icb_cmd_addr  (b_cmd_addr),
        .o_bus_icb_cmd_wdata (b_cmd_wdata),
        .o_bus_icb_cmd_wmask (b_cmd_wmask),
        .o_bus_icb_cmd_usr   (b_cmd_usr),
        .o_bus_icb_rsp_vld   (b_rsp_vld),
        .o_bus_icb_rsp_rdy   (b_rsp_rdy),
        .o_bus_icb_rsp_err   (b_rsp_err),
        .o_bus_icb_rsp_rdata (b_rsp_rdata),
        .o_bus_icb_rsp_usr   (b_rsp_usr)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: queue of outstanding target indices (N = error target),
    // oldest first. Address map: port k owns addr[31:28] == k+1.
    int q[$];

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < N; k++) begin
            if (a[31:28] == 4'(k + 1)) return k;
        end
        return N;
    endfunction

    function automatic bit m_accept();
        int t;
        t = decode(cmd_addr);
        if (!cmd_vld || q.size() >= DP) return 1'b0;
        return (t == N) ? 1'b1 : b_cmd_rdy[t];
    endfunction

    function automatic bit m_rsp_vld();
        if (q.size() == 0) return 1'b0;
        return (q[0] == N) ? 1'b1 : b_rsp_vld[q[0]];
    endfunction

    always @(posedge clk) begin : model_update
        bit acc, pop;
        int t;
        t   = decode(cmd_addr);
        acc = m_accept();
        pop = m_rsp_vld() && rsp_rdy;
        if (!rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(t);
        end
    end

    bit chk_on = 1'b0;

    always @(negedge clk) begin : compare
        int t, h;
        bit full;
        logic [N-1:0] ev, erdy;
        logic         evld, eerr;
        logic [31:0]  edat;
        logic         eusr;
        if (chk_on) begin
            t    = decode(cmd_addr);
            full = (q.size() >= DP);
            ev   = '0;
            if (cmd_vld && !full && t < N) ev[t] = 1'b1;
            chk("m_cmd_vld", 128'(b_cmd_vld), 128'(ev));
            chk("m_cmd_rdy", 128'(cmd_rdy),
                128'(!full && ((t == N) ? 1'b1 : b_cmd_rdy[t])));
            chk("m_bcast_addr",  128'(b_cmd_addr),  128'({N{cmd_addr}}));
            chk("m_bcast_wdata", 128'(b_cmd_wdata), 128'({N{cmd_wdata}}));
            chk("m_bcast_misc",  128'({b_cmd_read, b_cmd_wmask, b_cmd_usr}),
                128'({{N{cmd_read}}, {N{cmd_wmask}}, {N{cmd_usr}}}));
            h    = (q.size() > 0) ? q[0] : -1;
            erdy = '0; evld = 1'b0; eerr = 1'b0; edat = '0; eusr = 1'b0;
            if (h == N) begin
                evld = 1'b1;
                eerr = 1'b1;
            end else if (h >= 0) begin
                evld = b_rsp_vld[h];
                eerr = b_rsp_err[h];
                edat = p_rdata[h];
                eusr = b_rsp_usr[h];
                erdy[h] = rsp_rdy;
            end
            chk("m_rsp", 128'({rsp_vld, rsp_err, rsp_usr, rsp_rdata}),
                128'({evld, eerr, eusr, edat}));
            chk("m_bus_rsp_rdy", 128'(b_rsp_rdy), 128'(erdy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit rd, input logic [31:0] a, input logic [31:0] wd);
        cmd_vld   = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
    endtask

    task automatic clear_rsp();
        b_rsp_vld = '0;
        b_rsp_err = '0;
        b_rsp_usr = '0;
        rsp_rdy   = 1'b0;
        for (int k = 0; k < N; k++) p_rdata[k] = '0;
    endtask

    initial begin
        rst       = 1'b0;
        cmd_vld   = 1'b0;
        cmd_read  = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wmask = 4'hF;
        cmd_usr   = 1'b0;
        b_cmd_rdy = '1;
        clear_rsp();
        chk_on    = 1'b1;

        // Reset state: empty FIFO, address 0 decodes to the error target.
        @(negedge clk);
        chk("rst_rsp_vld", 128'(rsp_vld), 128'(0));
        chk("rst_cmd_vld", 128'(b_cmd_vld), 128'(0));
        chk("rst_bus_rdy", 128'(b_rsp_rdy), 128'(0));
        chk("rst_cmd_rdy", 128'(cmd_rdy), 128'(1));
        tick();
        rst = 1'b1;
        tick();

        // Write to port 1; same-cycle port response must not be forwarded.
        send(1'b0, 32'h2000_0010, 32'hDEAD_BEEF);
        cmd_wmask  = 4'h3;
        cmd_usr    = 1'b1;
        b_rsp_vld  = 4'b0010;
        p_rdata[1] = 32'h1111_2222;
        rsp_rdy    = 1'b1;
        @(negedge clk);
        chk("w_cmd_vld", 128'(b_cmd_vld), 128'(4'b0010));
        chk("w_cmd_rdy", 128'(cmd_rdy), 128'(1));
        chk("w_zero_cyc_vld", 128'(rsp_vld), 128'(0));
        chk("w_zero_cyc_rdy", 128'(b_rsp_rdy), 128'(0));
        tick();
        cmd_vld = 1'b0;
        cmd_usr = 1'b0;
        @(negedge clk);
        chk("w_rsp_vld", 128'(rsp_vld), 128'(1));
        chk("w_rsp_rdata", 128'(rsp_rdata), 128'(32'h1111_2222));
        chk("w_bus_rdy", 128'(b_rsp_rdy), 128'(4'b0010));
        tick();
        clear_rsp();

        // Unmapped read -> error target, answered the next cycle.
        send(1'b1, 32'h9000_0000, 32'h0);
        @(negedge clk);
        chk("e_cmd_vld", 128'(b_cmd_vld), 128'(0));
        chk("e_cmd_rdy", 128'(cmd_rdy), 128'(1));
        tick();
        cmd_vld = 1'b0;
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("e_rsp", 128'({rsp_vld, rsp_err, rsp_rdata}), 128'({1'b1, 1'b1, 32'h0}));
        tick();
        clear_rsp();

        // Ordering: port 0 then port 2; early port 2 response is held.
        send(1'b1, 32'h1000_0004, 32'h0);
        tick();
        send(1'b1, 32'h3000_0008, 32'h0);
        tick();
        cmd_vld    = 1'b0;
        rsp_rdy    = 1'b1;
        b_rsp_vld  = 4'b0100;
        p_rdata[2] = 32'h0000_3333;
        @(negedge clk);
        chk("o_hold_vld", 128'(rsp_vld), 128'(0));
        chk("o_hold_rdy", 128'(b_rsp_rdy), 128'(4'b0001));
        tick();
        b_rsp_vld  = 4'b0101;
        p_rdata[0] = 32'h0000_AAAA;
        @(negedge clk);
        chk("o_first", 128'({rsp_vld, rsp_rdata}), 128'({1'b1, 32'h0000_AAAA}));
        tick();
        b_rsp_vld = 4'b0100;
        @(negedge clk);
        chk("o_second", 128'({rsp_vld, rsp_rdata}), 128'({1'b1, 32'h0000_3333}));
        chk("o_second_rdy", 128'(b_rsp_rdy), 128'(4'b0100));
        tick();
        clear_rsp();

        // Full FIFO: third command stalls; a pop frees it only next cycle.
        send(1'b0, 32'h2000_0000, 32'h0000_0001);
        tick();
        tick();
        rsp_rdy    = 1'b1;
        b_rsp_vld  = 4'b0010;
        p_rdata[1] = 32'h0000_0B01;
        @(negedge clk);
        chk("f_cmd_rdy", 128'(cmd_rdy), 128'(0));
        chk("f_cmd_vld", 128'(b_cmd_vld), 128'(0));
        chk("f_pop_vld", 128'(rsp_vld), 128'(1));
        tick();
        clear_rsp();
        @(negedge clk);
        chk("f_cmd_rdy_after", 128'(cmd_rdy), 128'(1));
        chk("f_cmd_vld_after", 128'(b_cmd_vld), 128'(4'b0010));
        tick();
        cmd_vld    = 1'b0;
        rsp_rdy    = 1'b1;
        b_rsp_vld  = 4'b0010;
        p_rdata[1] = 32'h0000_0B02;
        tick();
        tick();
        clear_rsp();

        // Downstream not ready: valid still presented, upstream not ready.
        b_cmd_rdy = 4'b1011;
        send(1'b0, 32'h3000_0000, 32'h0);
        @(negedge clk);
        chk("n_cmd_vld", 128'(b_cmd_vld), 128'(4'b0100));
        chk("n_cmd_rdy", 128'(cmd_rdy), 128'(0));
        tick();
        b_cmd_rdy = '1;
        cmd_vld   = 1'b0;
        tick();

        // Backpressure on the upstream response for 5 cycles.
        send(1'b1, 32'h4000_0100, 32'h0);
        tick();
        cmd_vld    = 1'b0;
        b_rsp_vld  = 4'b1000;
        b_rsp_err  = 4'b1000;
        b_rsp_usr  = 4'b1000;
        p_rdata[3] = 32'h5A5A_0003;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_stable", 128'({rsp_vld, rsp_err, rsp_usr, rsp_rdata}),
                128'({1'b1, 1'b1, 1'b1, 32'h5A5A_0003}));
            tick();
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        chk("b_release_rdy", 128'(b_rsp_rdy), 128'(4'b1000));
        tick();
        clear_rsp();
        @(negedge clk);
        chk("b_empty_vld", 128'(rsp_vld), 128'(0));
        tick();

        // Reset with two outstanding: late responses never forwarded.
        send(1'b1, 32'h1000_0000, 32'h0);
        tick();
        send(1'b1, 32'h2000_0000, 32'h0);
        tick();
        cmd_vld    = 1'b0;
        rst        = 1'b0;
        b_rsp_vld  = 4'b0011;
        p_rdata[0] = 32'h0000_0F00;
        p_rdata[1] = 32'h0000_0F01;
        tick();
        rst     = 1'b1;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("r_rsp_vld", 128'(rsp_vld), 128'(0));
            chk("r_bus_rdy", 128'(b_rsp_rdy), 128'(0));
            chk("r_cmd_rdy", 128'(cmd_rdy), 128'(1));
            tick();
        end
        clear_rsp();
        tick();

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
